csi_tx_packet_builder: RTL and testbench

Upstream neighbour of the D-PHY master adapter layer: converts CSI-2 packet requests (data identifier, word count, payload byte stream) into a complete low-level-protocol byte stream. The stream is header + ECC, payload, CRC-16, then zero padding to a lane multiple. The block pushes the whole burst into the shared TX fifo, then issues the one-cycle `TxRequestHS` strobe with `BurstSize` on the APPI side. Before accepting the next packet it waits for the PHY to leave and re-enter Stopstate.

---
 rtl/csi_tx_packet_builder.sv | 352 +++++++++++++++++++++++++++++++++++
 tb/tb_csi_tx_packet_builder.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_tx_packet_builder.sv
// ---------------------------------------------------------------------------
// csi_tx_packet_builder
//
// Turns a CSI-2 packet request (data identifier, word count, payload byte
// stream) into a complete low-level-protocol byte burst. The burst is
// written into the shared TX fifo, then a one-cycle TxRequestHS is raised
// with the padded burst length. The block then waits for the PHY to leave
// and re-enter Stopstate before it accepts the next request.
//
// Burst layout:
//   DI, WC[7:0], WC[15:8], ECC                      (short: DT < 0x10)
//   DI, WC[7:0], WC[15:8], ECC, payload, CRC lo, CRC hi   (long)
//   followed by 0x00 bytes up to a multiple of N_DATA_LANES.
// Requests whose padded length exceeds FIFO_DEPTH are rejected: pkt_err
// pulses and the payload is drained without touching the fifo.
//
// Ports:
//   hs_tx_word_clk       HS TX word clock, only clock of this block
//   rst                  synchronous active-high reset
//   pkt_valid/pkt_ready  packet request handshake
//   pkt_di, pkt_wc       data identifier {VC,DT} and word count
//   pld_valid/pld_ready  payload byte handshake, pld_data byte
//   fifo_push/fifo_data  byte write into the TX fifo, fifo_full backpressure
//   TxRequestHS          one-cycle burst request to the D-PHY adapter
//   BurstSize            padded burst byte count, stable until IDLE
//   Stopstate            lane stop state from the adapter
//   pkt_err              one-cycle pulse for an oversize request
//   busy                 high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module csi_tx_packet_builder #(
    parameter int N_DATA_LANES = 4,
    parameter int FIFO_DEPTH   = 4096
) (
    input  logic        hs_tx_word_clk,
    input  logic        rst,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [7:0]  pkt_di,
    input  logic [15:0] pkt_wc,
    input  logic        pld_valid,
    output logic        pld_ready,
    input  logic [7:0]  pld_data,
    output logic        fifo_push,
    output logic [7:0]  fifo_data,
    input  logic        fifo_full,
    output logic        TxRequestHS,
    output logic [15:0] BurstSize,
    input  logic        Stopstate,
    output logic        pkt_err,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_PLD,
        S_CRC,
        S_PAD,
        S_REQ,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_DRAIN
    } state_t;

    // Length arithmetic is done in 18 bits: a 65535-byte payload plus
    // header, CRC and pad does not fit in 16.
    localparam logic [17:0] LANES = 18'(N_DATA_LANES);
    localparam logic [17:0] DEPTH = 18'(FIFO_DEPTH);

    // Row masks of the CSI-2 header Hamming code: ECC bit i is the parity
    // of the 24 header bits selected by ECC_MASK[i].
    localparam logic [5:0][23:0] ECC_MASK = {
        24'hEFFC00,   // P5
        24'hDF03F0,   // P4
        24'hB8E38E,   // P3
        24'h749A6D,   // P2
        24'hF2555B,   // P1
        24'hF12CB7    // P0
    };

    // Reflected CRC-16 (0x8408) update for one byte, LSB first.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc_in,
                                                 input logic [7:0]  data_in);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [7:0]  di_q, di_d;
    logic [15:0] wc_q, wc_d;
    logic [7:0]  ecc_q, ecc_d;
    logic [15:0] pad_q, pad_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] burst_q, burst_d;
    logic        err_q, err_d;

    // ------------------------------------------------------------------
    // Accept-time computations, taken straight from the request inputs
    // ------------------------------------------------------------------
    logic [23:0] hdr_word;
    logic [5:0]  ecc_par;
    logic        acc_long;
    logic [17:0] raw_len;
    logic [17:0] raw_mod;
    logic [15:0] pad_len;
    logic [17:0] padded_len;
    logic        oversize;
    logic        cur_long;

    assign hdr_word = {pkt_wc, pkt_di};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_ecc
            assign ecc_par[gi] = ^(hdr_word & ECC_MASK[gi]);
        end
    endgenerate

    always_comb begin
        acc_long   = (pkt_di[5:0] >= 6'h10);
        raw_len    = acc_long ? (18'(pkt_wc) + 18'd6) : 18'd4;
        raw_mod    = raw_len % LANES;
        pad_len    = (raw_mod == 18'd0) ? 16'd0 : 16'(LANES - raw_mod);
        padded_len = raw_len + 18'(pad_len);
        oversize   = (padded_len > DEPTH);
    end

    assign cur_long = (di_q[5:0] >= 6'h10);

    // ------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge hs_tx_word_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            di_q    <= 8'h00;
            wc_q    <= 16'h0000;
            ecc_q   <= 8'h00;
            pad_q   <= 16'h0000;
            cnt_q   <= 16'h0000;
            crc_q   <= 16'hFFFF;
            burst_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            di_q    <= di_d;
            wc_q    <= wc_d;
            ecc_q   <= ecc_d;
            pad_q   <= pad_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            burst_q <= burst_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state and datapath update
    // cnt_q is a shared byte index: header byte, payload byte, CRC byte
    // or pad byte depending on the state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        di_d    = di_q;
        wc_d    = wc_q;
        ecc_d   = ecc_q;
        pad_d   = pad_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        burst_d = burst_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pkt_valid && pkt_ready) begin
                    di_d  = pkt_di;
                    wc_d  = pkt_wc;
                    ecc_d = {2'b00, ecc_par};
                    pad_d = pad_len;
                    cnt_d = 16'd0;
                    crc_d = 16'hFFFF;
                    if (oversize) begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end else begin
                        burst_d = padded_len[15:0];
                        state_d = S_HDR;
                    end
                end
            end

            S_HDR: begin
                if (!fifo_full) begin
                    if (cnt_q == 16'd3) begin
                        cnt_d = 16'd0;
                        if (cur_long) begin
                            state_d = (wc_q != 16'd0) ? S_PLD : S_CRC;
                        end else begin
                            state_d = (pad_q != 16'd0) ? S_PAD : S_REQ;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            S_PLD: begin
                if (pld_valid && !fifo_full) begin
                    crc_d = crc16_update(crc_q, pld_data);
                    if (cnt_q == wc_q - 16'd1) begin
                        cnt_d   = 16'd0;
                        state_d = S_CRC;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            S_CRC: begin
                if (!fifo_full) begin
                    if (cnt_q == 16'd1) begin
                        cnt_d   = 16'd0;
                        state_d = (pad_q != 16'd0) ? S_PAD : S_REQ;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            S_PAD: begin
                if (!fifo_full) begin
                    if (cnt_q == pad_q - 16'd1) begin
                        cnt_d   = 16'd0;
                        state_d = S_REQ;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            S_REQ: begin
                state_d = S_WAIT_LOW;
            end

            // Stopstate low means the adapter has started the burst.
            S_WAIT_LOW: begin
                if (!Stopstate) begin
                    state_d = S_WAIT_HIGH;
                end
            end

            S_WAIT_HIGH: begin
                if (Stopstate) begin
                    state_d = S_IDLE;
                end
            end

            // Oversize request: swallow the payload, never touch the fifo.
            S_DRAIN: begin
                if (wc_q == 16'd0) begin
                    state_d = S_IDLE;
                end else if (pld_valid) begin
                    if (cnt_q == wc_q - 16'd1) begin
                        cnt_d   = 16'd0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: outputs
    // Strobes are masked by rst so nothing leaks out during the reset
    // cycle itself, even when reset lands mid-packet.
    // ------------------------------------------------------------------
    always_comb begin
        pkt_ready   = 1'b0;
        pld_ready   = 1'b0;
        fifo_push   = 1'b0;
        fifo_data   = 8'h00;
        TxRequestHS = 1'b0;

        case (state_q)
            S_IDLE: begin
                pkt_ready = 1'b1;
            end

            S_HDR: begin
                fifo_push = !fifo_full;
                case (cnt_q[1:0])
                    2'd0:    fifo_data = di_q;
                    2'd1:    fifo_data = wc_q[7:0];
                    2'd2:    fifo_data = wc_q[15:8];
                    default: fifo_data = ecc_q;
                endcase
            end

            S_PLD: begin
                pld_ready = !fifo_full;
                fifo_push = pld_valid && !fifo_full;
                fifo_data = pld_data;
            end

            S_CRC: begin
                fifo_push = !fifo_full;
                fifo_data = (cnt_q == 16'd0) ? crc_q[7:0] : crc_q[15:8];
            end

            S_PAD: begin
                fifo_push = !fifo_full;
                fifo_data = 8'h00;
            end

            S_REQ: begin
                TxRequestHS = 1'b1;
            end

            S_DRAIN: begin
                pld_ready = 1'b1;
            end

            default: begin
            end
        endcase

        if (rst) begin
            pkt_ready   = 1'b0;
            pld_ready   = 1'b0;
            fifo_push   = 1'b0;
            TxRequestHS = 1'b0;
        end
    end

    assign BurstSize = burst_q;
    assign pkt_err   = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_csi_tx_packet_builder.sv
// ---------------------------------------------------------------------------
// Testbench for csi_tx_packet_builder.
// The driver builds each expected burst from the packet rules (header with
// column-table ECC, payload, bit-serial CRC-16, zero pad) and pushes it into
// a scoreboard queue at accept time; an independent monitor pops and
// compares on every fifo push, request strobe and error pulse.
// ---------------------------------------------------------------------------
module tb_csi_tx_packet_builder;

    localparam int N_LANES = 4;
    localparam int DEPTH   = 4096;

    logic        clk;
    logic        rst;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [7:0]  pkt_di;
    logic [15:0] pkt_wc;
    logic        pld_valid;
    logic        pld_ready;
    logic [7:0]  pld_data;
    logic        fifo_push;
    logic [7:0]  fifo_data;
    logic        fifo_full;
    logic        TxRequestHS;
    logic [15:0] BurstSize;
    logic        Stopstate;
    logic        pkt_err;
    logic        busy;

    csi_tx_packet_builder #(
        .N_DATA_LANES(N_LANES),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .hs_tx_word_clk(clk),
        .rst           (rst),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .pkt_di        (pkt_di),
        .pkt_wc        (pkt_wc),
        .pld_valid     (pld_valid),
        .pld_ready     (pld_ready),
        .pld_data      (pld_data),
        .fifo_push     (fifo_push),
        .fifo_data     (fifo_data),
        .fifo_full     (fifo_full),
        .TxRequestHS   (TxRequestHS),
        .BurstSize     (BurstSize),
        .Stopstate     (Stopstate),
        .pkt_err       (pkt_err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_bytes[$];
    logic [15:0] exp_bs[$];
    int          err_cyc_q[$];
    int          exp_req_cyc = -1;
    int          full_hold   = 0;
    bit          rand_full   = 1'b0;
    int          ss_low      = 1;
    int          ss_high     = 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // ECC as XOR of per-data-bit syndrome columns.
    function automatic logic [5:0] ecc_col(input int i);
        case (i)
            0: return 6'h07;   1: return 6'h0B;   2: return 6'h0D;   3: return 6'h0E;
            4: return 6'h13;   5: return 6'h15;   6: return 6'h16;   7: return 6'h19;
            8: return 6'h1A;   9: return 6'h1C;  10: return 6'h23;  11: return 6'h25;
           12: return 6'h26;  13: return 6'h29;  14: return 6'h2A;  15: return 6'h2C;
           16: return 6'h31;  17: return 6'h32;  18: return 6'h34;  19: return 6'h38;
           20: return 6'h1F;  21: return 6'h2F;  22: return 6'h37;  23: return 6'h3B;
            default: return 6'h00;
        endcase
    endfunction

    function automatic logic [7:0] model_ecc(input logic [23:0] h);
        logic [5:0] e;
        e = 6'h00;
        for (int i = 0; i < 24; i++) begin
            if (h[i]) e = e ^ ecc_col(i);
        end
        return {2'b00, e};
    endfunction

    // Bit-serial LFSR, x^16+x^12+x^5+1 reflected, LSB of each byte first.
    function automatic logic [15:0] model_crc(input logic [7:0] d[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (d[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[k][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_pkt_ready"},   32'(pkt_ready),   32'd1);
        check({tag, "_pld_ready"},   32'(pld_ready),   32'd0);
        check({tag, "_fifo_push"},   32'(fifo_push),   32'd0);
        check({tag, "_fifo_data"},   32'(fifo_data),   32'd0);
        check({tag, "_txreq"},       32'(TxRequestHS), 32'd0);
        check({tag, "_burstsize"},   32'(BurstSize),   32'd0);
        check({tag, "_pkt_err"},     32'(pkt_err),     32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
    endtask

    // ---------------- fifo backpressure generator ----------------
    initial begin
        fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (full_hold > 0) begin
                fifo_full = 1'b1;
                full_hold--;
            end else begin
                fifo_full = rand_full ? ($urandom_range(0, 4) == 0) : 1'b0;
            end
        end
    end

    // ---------------- Stopstate responder ----------------
    initial begin
        Stopstate = 1'b1;
        forever begin
            @(negedge clk);
            if (TxRequestHS) begin
                repeat (ss_low) @(posedge clk);
                #1 Stopstate = 1'b0;
                repeat (ss_high) @(posedge clk);
                #1 Stopstate = 1'b1;
                @(negedge clk);
                check("ready_low_at_stop_rise", 32'(pkt_ready), 32'd0);
                @(negedge clk);
                check("ready_after_stop_rise", 32'(pkt_ready), 32'd1);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        prev_req;
        logic        req_seen;
        logic [15:0] held_bs;
        logic [7:0]  eb;
        prev_req = 1'b0;
        req_seen = 1'b0;
        held_bs  = 16'h0;
        forever begin
            @(negedge clk);
            if (fifo_push) begin
                check("no_push_when_full", 32'(fifo_full), 32'd0);
                if (exp_bytes.size() == 0) begin
                    check("unexpected_push", 32'(fifo_data), 32'hFFFF_FFFF);
                end else begin
                    eb = exp_bytes.pop_front();
                    check("fifo_byte", 32'(fifo_data), 32'(eb));
                end
            end
            if (TxRequestHS) begin
                check("req_single_cycle", 32'(prev_req), 32'd0);
                check("bytes_before_req", 32'(exp_bytes.size()), 32'd0);
                if (exp_bs.size() == 0) begin
                    check("unexpected_req", 32'(BurstSize), 32'hFFFF_FFFF);
                end else begin
                    check("burst_size", 32'(BurstSize), 32'(exp_bs.pop_front()));
                end
                if (exp_req_cyc >= 0) begin
                    check("req_latency", 32'(cyc), 32'(exp_req_cyc));
                    exp_req_cyc = -1;
                end
                req_seen = 1'b1;
                held_bs  = BurstSize;
            end
            if (req_seen && !busy) begin
                check("burst_size_held", 32'(BurstSize), 32'(held_bs));
                req_seen = 1'b0;
            end
            if (pkt_err) begin
                if (err_cyc_q.size() == 0) begin
                    check("unexpected_err", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    check("err_pulse_cycle", 32'(cyc), 32'(err_cyc_q.pop_front()));
                end
            end
            prev_req = TxRequestHS;
        end
    end

    // ---------------- driver ----------------
    task automatic reset_mid_packet();
        rst       = 1'b1;
        pld_valid = 1'b0;
        exp_bytes.delete();
        exp_bs.delete();
        err_cyc_q.delete();
        @(negedge clk);
        check("ready_in_reset", 32'(pkt_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_rst");
    endtask

    task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc,
                            input int abort_at, input int full_at,
                            input bit vtoggle, input bit lat_chk);
        logic [7:0]  pl[$];
        logic [7:0]  exp[$];
        logic [15:0] crc;
        bit          lng;
        bit          taken;
        int          guard;

        lng = (di[5:0] >= 6'h10);
        if (lng) begin
            for (int i = 0; i < int'(wc); i++) pl.push_back(8'($urandom));
        end
        exp.push_back(di);
        exp.push_back(wc[7:0]);
        exp.push_back(wc[15:8]);
        exp.push_back(model_ecc({wc, di}));
        if (lng) begin
            foreach (pl[k]) exp.push_back(pl[k]);
            crc = model_crc(pl);
            exp.push_back(crc[7:0]);
            exp.push_back(crc[15:8]);
        end
        while ((exp.size() % N_LANES) != 0) exp.push_back(8'h00);

        @(posedge clk);
        #1;
        pkt_di    = di;
        pkt_wc    = wc;
        pkt_valid = 1'b1;
        guard     = 0;
        while (1) begin
            @(negedge clk);
            if (pkt_ready) break;
            guard++;
            if (guard > 500) begin
                fail_now("accept_timeout");
                pkt_valid = 1'b0;
                return;
            end
        end
        // Accepted at the coming edge; the first cycle after it is cyc+1.
        if (exp.size() > DEPTH) begin
            err_cyc_q.push_back(cyc + 1);
        end else begin
            foreach (exp[k]) exp_bytes.push_back(exp[k]);
            exp_bs.push_back(16'(exp.size()));
            if (lat_chk) exp_req_cyc = cyc + 1 + 4;
        end
        @(posedge clk);
        #1 pkt_valid = 1'b0;

        if (lng) begin
            for (int i = 0; i < int'(wc); i++) begin
                if (i == abort_at) begin
                    reset_mid_packet();
                    return;
                end
                if (i == full_at) full_hold = 3;
                pld_data = pl[i];
                taken    = 1'b0;
                guard    = 0;
                while (!taken) begin
                    pld_valid = vtoggle ? ($urandom_range(0, 3) != 0) : 1'b1;
                    @(negedge clk);
                    if (pld_valid && pld_ready) taken = 1'b1;
                    @(posedge clk);
                    #1;
                    guard++;
                    if (guard > 300) begin
                        fail_now("payload_timeout");
                        pld_valid = 1'b0;
                        return;
                    end
                end
            end
            pld_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (1) begin
            @(negedge clk);
            if (!busy) break;
            guard++;
            if (guard > 6000) begin
                fail_now("idle_timeout");
                return;
            end
        end
    endtask

    initial begin
        logic [7:0]  rdi;
        logic [15:0] rwc;
        rst       = 1'b1;
        pkt_valid = 1'b0;
        pkt_di    = 8'h00;
        pkt_wc    = 16'h0000;
        pld_valid = 1'b0;
        pld_data  = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", 32'(pkt_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("por");

        // Short packet, all zero, request latency check.
        send_pkt(8'h00, 16'h0000, -1, -1, 1'b0, 1'b1);
        wait_idle();

        // Long packet with empty payload: CRC is the bare seed.
        send_pkt(8'h2A, 16'h0000, -1, -1, 1'b0, 1'b0);
        wait_idle();

        // Long WC=5, toggling valid, 3-cycle fifo_full mid-payload.
        send_pkt(8'h2B, 16'd5, -1, 2, 1'b1, 1'b0);
        wait_idle();

        // Exactly FIFO_DEPTH after padding: accepted.
        send_pkt(8'h2C, 16'd4090, -1, -1, 1'b0, 1'b0);
        wait_idle();

        // Oversize: drained, no pushes, no request.
        send_pkt(8'h2C, 16'd4095, -1, -1, 1'b1, 1'b0);
        wait_idle();
        check("idle_after_drain", 32'(busy), 32'd0);

        // Back-to-back with slow Stopstate turnaround.
        ss_low  = 3;
        ss_high = 37;
        send_pkt(8'h05, 16'hBEEF, -1, -1, 1'b0, 1'b0);
        send_pkt(8'h6D, 16'd7, -1, -1, 1'b1, 1'b0);
        wait_idle();
        ss_low  = 1;
        ss_high = 2;

        // Reset during payload, then a clean packet with reseeded CRC.
        send_pkt(8'h1E, 16'd20, 6, -1, 1'b1, 1'b0);
        send_pkt(8'h1E, 16'd9, -1, -1, 1'b1, 1'b0);
        wait_idle();

        // Randomized traffic with random backpressure.
        rand_full = 1'b1;
        for (int n = 0; n < 20; n++) begin
            ss_low  = $urandom_range(1, 4);
            ss_high = $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0) begin
                rdi = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 15))};
                rwc = 16'($urandom);
            end else begin
                rdi = {2'($urandom_range(0, 3)), 6'($urandom_range(16, 63))};
                rwc = 16'($urandom_range(0, 40));
            end
            send_pkt(rdi, rwc, -1, -1, 1'b1, 1'b0);
            wait_idle();
        end
        rand_full = 1'b0;

        repeat (4) @(negedge clk);
        check("sb_bytes_empty", 32'(exp_bytes.size()), 32'd0);
        check("sb_bs_empty",    32'(exp_bs.size()),    32'd0);
        check("sb_err_empty",   32'(err_cyc_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
